fb_port_a_arbiter: RTL and testbench
====================================

Name: fb_port_a_arbiter

Overview:
- Owns framebuffer port A (8-bit write side of multimem) and shares it between two write requesters:
  - req0: control_module UART image loader.
  - req1: debugger-driven pixel poke path.
- Contains an internal clear engine that sweeps the whole framebuffer with a fill byte.
- Sits between the requesters and multimem port A; all in the clk_root domain.

Parameters:
- ADDR_WIDTH, 12, port A address width.
- DATA_WIDTH, 8, port A data width.
- CLEAR_LAST, 12'd4095, last address written by a clear sweep; sweep covers 0..CLEAR_LAST.
- MAX_BURST, 4'd8, consecutive req0 grants allowed while req1 is waiting; must be ≥1.

Ports:
- clk_in  in  1  clk_root.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  req0 has a write pending.
- req0_addr  in  ADDR_WIDTH  req0 write address.
- req0_data  in  DATA_WIDTH  req0 write data.
- req0_ready  out  1  req0 write accepted this cycle.
- req1_valid  in  1  req1 has a write pending.
- req1_addr  in  ADDR_WIDTH  req1 write address.
- req1_data  in  DATA_WIDTH  req1 write data.
- req1_ready  out  1  req1 write accepted this cycle.
- clear_start  in  1  single-cycle pulse: begin clear sweep.
- clear_value  in  DATA_WIDTH  fill byte, sampled on accepted clear_start.
- clear_busy  out  1  clear sweep in progress.
- grant_owner  out  2  source of the write now on the RAM outputs: 0 none, 1 req0, 2 req1, 3 clear.
- ram_address  out  ADDR_WIDTH  to multimem AddressA.
- ram_data_out  out  DATA_WIDTH  to multimem DataInA.
- ram_write_enable  out  1  to WrA.
- ram_clk_enable  out  1  to ClockEnA.

Behaviour:
- Reset (reset==0 at a clk_in edge):
  - state=IDLE; burst counter=0.
  - All registered outputs 0: ram_*, grant_owner, clear_busy.
  - req0_ready/req1_ready forced 0 while reset is low.
  - Reset mid-sweep aborts the sweep; no further writes.
- Handshake:
  - A write is accepted when valid && ready in the same cycle.
  - ready is combinational from state, valids and burst counter; never asserted without the matching valid.
  - A requester must hold addr/data stable while valid && !ready.
- Latency: an accepted write appears on ram_address/ram_data_out with ram_write_enable=ram_clk_enable=1 on the next cycle. Exactly one RAM write per cycle max.
- On cycles with no write, ram_write_enable=0 and ram_clk_enable=0; ram_address/ram_data_out hold their last values.
- State IDLE arbitration:
  - Only req0 valid → req0.
  - Only req1 valid → req1.
  - Both valid:
    - req0 wins while burst_cnt < MAX_BURST; each such grant increments burst_cnt.
    - When burst_cnt == MAX_BURST, req1 is granted and burst_cnt clears.
  - burst_cnt also clears on any cycle where req1 is not valid.
- clear_start:
  - Accepted only in IDLE; clear_start in CLEAR is ignored.
  - It takes precedence over both requesters in the same cycle: both readys are 0 that cycle.
  - On acceptance: latch clear_value; sweep address=0; state=CLEAR.
- State CLEAR:
  - Both readys are 0.
  - Each cycle issue a write of the latched value at the sweep address, then address+1.
  - After the write to CLEAR_LAST, return to IDLE; the address counter does not wrap.
  - First clear write appears on RAM outputs one cycle after acceptance; CLEAR_LAST+1 writes total.
- clear_busy:
  - 1 from the cycle after acceptance through the cycle the CLEAR_LAST write is on the RAM outputs.
  - 0 on the following cycle.
  - Requesters may be granted in the cycle after the last clear write issues.
- grant_owner is registered alongside the RAM outputs; 0 on idle cycles.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- Defined:
  - Adds output write_count[15:0]: counts every committed RAM write (ram_write_enable==1) from any source.
  - Wraps 16'hFFFF→0; reset to 0.
  - Adds output starve_events[7:0]: increments each time a MAX_BURST-forced req1 grant occurs; saturates at 8'hFF.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset held low 3 cycles with req0_valid=1 → both readys 0, all ram_* 0, grant_owner=0. Release → req0_ready=1 on the next cycle.
- req0 single write addr=12'h123 data=8'hA5 → next cycle ram_address=12'h123, ram_data_out=8'hA5, WE=CE=1, grant_owner=1. Following cycle WE=0.
- req0 and req1 held valid continuously, MAX_BURST=8 → grant pattern 8×req0, 1×req1, repeating. With stats enabled, starve_events increments once per pattern.
- clear_start with clear_value=8'h00, CLEAR_LAST=15 → 16 consecutive writes to addresses 0..15, data 0, grant_owner=3. clear_busy high exactly 16 cycles. req0_valid held throughout → first req0 write immediately after the sweep.
- clear_start pulsed again at sweep address 5 → ignored; sweep completes at 15 with no restart.
- reset driven low at sweep address 7 → next cycle WE=0 and clear_busy=0. After release, no clear writes resume.

Source files
------------

// File: rtl/fb_port_a_arbiter.sv
// Purpose: owns framebuffer port A and shares it between req0 (UART loader),
//          req1 (debugger poke) and an internal clear engine that fills 0..CLEAR_LAST.
// Latency: an accepted write is on the ram_* outputs one cycle after acceptance.
// Backpressure: combinational ready. req0 gets at most MAX_BURST back-to-back grants
//               while req1 waits. A clear sweep holds both readys low until it ends.
// Ports: clk_in, reset (synchronous, active-low); req0_*/req1_* valid/ready write requests;
//        clear_start/clear_value/clear_busy for the clear engine; ram_* to multimem port A;
//        grant_owner gives the source of the write on the RAM outputs (0 none, 1 req0, 2 req1, 3 clear).
// Optional: define FB_ARB_STATS_EN to add the write_count and starve_events counters.
module fb_port_a_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] CLEAR_LAST = 12'd4095,
    parameter logic [3:0]            MAX_BURST  = 4'd8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  clear_busy,
    output logic [1:0]            grant_owner,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_write_enable,
    output logic                  ram_clk_enable
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]           write_count,
    output logic [7:0]            starve_events
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_REQ0  = 2'd1;
    localparam logic [1:0] OWN_REQ1  = 2'd2;
    localparam logic [1:0] OWN_CLEAR = 2'd3;

    state_e                state_q, state_d;
    logic [3:0]            burst_q, burst_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;   // next sweep address to issue
    logic [DATA_WIDTH-1:0] clr_val_q, clr_val_d;

    logic [ADDR_WIDTH-1:0] ram_address_q;
    logic [DATA_WIDTH-1:0] ram_data_q;
    logic                  ram_we_q;
    logic [1:0]            owner_q;
    logic                  clear_busy_q;

    logic                  grant0, grant1, forced1, clr_wr, wr_issue;
    logic [ADDR_WIDTH-1:0] clr_wr_addr;
    logic [DATA_WIDTH-1:0] clr_wr_data;

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        clr_addr_d  = clr_addr_q;
        clr_val_d   = clr_val_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        forced1     = 1'b0;
        clr_wr      = 1'b0;
        clr_wr_addr = clr_addr_q;
        clr_wr_data = clr_val_q;

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    // Address 0 is issued on the accepting edge so the first
                    // fill write lands one cycle after acceptance.
                    clr_wr      = 1'b1;
                    clr_wr_addr = '0;
                    clr_wr_data = clear_value;
                    clr_val_d   = clear_value;
                    if (CLEAR_LAST != '0) begin
                        state_d    = ST_CLEAR;
                        clr_addr_d = ADDR_WIDTH'(1);
                    end
                end else if (req0_valid && req1_valid) begin
                    if (burst_q < MAX_BURST) begin
                        grant0  = 1'b1;
                        burst_d = burst_q + 4'd1;
                    end else begin
                        grant1  = 1'b1;
                        forced1 = 1'b1;
                    end
                end else if (req0_valid) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_wr = 1'b1;
                if (clr_addr_q == CLEAR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The burst window only measures how long req1 has been kept waiting.
        if (!req1_valid || grant1) begin
            burst_d = '0;
        end
    end

    assign wr_issue   = clr_wr | grant0 | grant1;
    assign req0_ready = reset & grant0;
    assign req1_ready = reset & grant1;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            burst_q       <= '0;
            clr_addr_q    <= '0;
            clr_val_q     <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_we_q      <= 1'b0;
            owner_q       <= OWN_NONE;
            clear_busy_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            clr_addr_q   <= clr_addr_d;
            clr_val_q    <= clr_val_d;
            ram_we_q     <= wr_issue;
            clear_busy_q <= clr_wr;
            // Address and data hold their last values on idle cycles.
            if (clr_wr) begin
                ram_address_q <= clr_wr_addr;
                ram_data_q    <= clr_wr_data;
                owner_q       <= OWN_CLEAR;
            end else if (grant0) begin
                ram_address_q <= req0_addr;
                ram_data_q    <= req0_data;
                owner_q       <= OWN_REQ0;
            end else if (grant1) begin
                ram_address_q <= req1_addr;
                ram_data_q    <= req1_data;
                owner_q       <= OWN_REQ1;
            end else begin
                owner_q       <= OWN_NONE;
            end
        end
    end

    assign ram_address      = ram_address_q;
    assign ram_data_out     = ram_data_q;
    assign ram_write_enable = ram_we_q;
    assign ram_clk_enable   = ram_we_q;
    assign grant_owner      = owner_q;
    assign clear_busy       = clear_busy_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] write_count_q;
    logic [7:0]  starve_q;

    // Counted on the issuing edge so write_count tracks the writes already on the RAM outputs.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            write_count_q <= '0;
            starve_q      <= '0;
        end else begin
            if (wr_issue) begin
                write_count_q <= write_count_q + 16'd1;
            end
            if (forced1 && (starve_q != 8'hFF)) begin
                starve_q <= starve_q + 8'd1;
            end
        end
    end

    assign write_count   = write_count_q;
    assign starve_events = starve_q;
`endif

endmodule

// File: tb/tb_fb_port_a_arbiter.sv
// Bench for fb_port_a_arbiter, built with CLEAR_LAST=15 and MAX_BURST=8.
// A reference model samples the inputs on each falling edge and predicts the
// readys for this cycle and the RAM outputs for the next cycle. Directed
// sections pin the model to literal values taken from the test plan.
module tb_fb_port_a_arbiter;

    localparam int CLR_LAST = 15;
    localparam int MAXB     = 8;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [11:0] req0_addr = '0, req1_addr = '0;
    logic [7:0]  req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        clear_start = 1'b0;
    logic [7:0]  clear_value = '0;
    logic        clear_busy;
    logic [1:0]  grant_owner;
    logic [11:0] ram_address;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable, ram_clk_enable;
`ifdef FB_ARB_STATS_EN
    logic [15:0] write_count;
    logic [7:0]  starve_events;
`endif

    fb_port_a_arbiter #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .CLEAR_LAST(12'd15),
        .MAX_BURST (4'd8)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .clear_start     (clear_start),
        .clear_value     (clear_value),
        .clear_busy      (clear_busy),
        .grant_owner     (grant_owner),
        .ram_address     (ram_address),
        .ram_data_out    (ram_data_out),
        .ram_write_enable(ram_write_enable),
        .ram_clk_enable  (ram_clk_enable)
`ifdef FB_ARB_STATS_EN
        ,
        .write_count     (write_count),
        .starve_events   (starve_events)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- reference model ----------------
    int          m_sweep = -1;   // next sweep address, -1 when no sweep is running
    int          m_run = 0;      // req0 grants given while req1 was waiting
    logic [7:0]  m_fill = '0;
    int          m_starve = 0;
    int          m_wc = 0;
    int          e_owner = 0;
    logic        e_we = 1'b0, e_busy = 1'b0;
    logic [11:0] e_addr = '0;
    logic [7:0]  e_data = '0;

    always @(negedge clk_in) begin
        int          g;
        int          s_prev;
        logic [11:0] a;
        logic [7:0]  d;
        g      = 0;
        a      = e_addr;
        d      = e_data;
        s_prev = m_starve;
        if (reset) begin
            if (m_sweep >= 0) begin
                g = 3; a = 12'(m_sweep); d = m_fill;
                m_sweep = (m_sweep == CLR_LAST) ? -1 : m_sweep + 1;
            end else if (clear_start) begin
                g = 3; a = 12'h000; d = clear_value; m_fill = clear_value;
                m_sweep = (CLR_LAST > 0) ? 1 : -1;
            end else if (req0_valid && req1_valid) begin
                if (m_run < MAXB) begin
                    g = 1; m_run++;
                end else begin
                    g = 2;
                    m_starve = (m_starve < 255) ? m_starve + 1 : 255;
                end
            end else if (req0_valid) begin
                g = 1;
            end else if (req1_valid) begin
                g = 2;
            end
            if (g == 1) begin a = req0_addr; d = req0_data; end
            if (g == 2) begin a = req1_addr; d = req1_data; end
            if (!req1_valid || g == 2) m_run = 0;
        end

        if (chk_en) begin
            check("req0_ready",  32'(req0_ready),       32'(g == 1));
            check("req1_ready",  32'(req1_ready),       32'(g == 2));
            check("ram_we",      32'(ram_write_enable), 32'(e_we));
            check("ram_ce",      32'(ram_clk_enable),   32'(e_we));
            check("ram_address", 32'(ram_address),      32'(e_addr));
            check("ram_data",    32'(ram_data_out),     32'(e_data));
            check("grant_owner", 32'(grant_owner),      32'(e_owner));
            check("clear_busy",  32'(clear_busy),       32'(e_busy));
`ifdef FB_ARB_STATS_EN
            check("write_count",   32'(write_count),   32'(m_wc));
            check("starve_events", 32'(starve_events), 32'(s_prev));
`endif
        end

        if (!reset) begin
            e_we = 1'b0; e_owner = 0; e_addr = '0; e_data = '0; e_busy = 1'b0;
            m_sweep = -1; m_run = 0; m_starve = 0; m_wc = 0;
        end else begin
            e_we    = (g != 0);
            e_owner = g;
            e_addr  = a;
            e_data  = d;
            e_busy  = (g == 3);
            if (g != 0) m_wc = (m_wc + 1) % 65536;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required end before t=400000");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  n_clear, n_busy, last_owner, n3;
        bit  found, p0, p1;

        // Reset held low with req0 requesting.
        reset = 1'b0;
        req0_valid = 1'b1;
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_req0_ready", 32'(req0_ready), 32'd0);
            check("rst_req1_ready", 32'(req1_ready), 32'd0);
            check("rst_we",         32'(ram_write_enable), 32'd0);
            check("rst_owner",      32'(grant_owner), 32'd0);
            check("rst_addr",       32'(ram_address), 32'd0);
            tick();
        end
        reset = 1'b1;
        req0_addr = 12'h123;
        req0_data = 8'hA5;
        #1;
        check("release_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("single_addr",  32'(ram_address),      32'h123);
        check("single_data",  32'(ram_data_out),     32'hA5);
        check("single_we",    32'(ram_write_enable), 32'd1);
        check("single_ce",    32'(ram_clk_enable),   32'd1);
        check("single_owner", 32'(grant_owner),      32'd1);
        tick();
        #1;
        check("single_we_after",   32'(ram_write_enable), 32'd0);
        check("single_addr_hold",  32'(ram_address),      32'h123);

        // Both requesters held: 8 x req0 then 1 x req1, repeating.
        req0_valid = 1'b1; req0_addr = 12'h010; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 12'h200; req1_data = 8'h22;
        for (int i = 0; i < 18; i++) begin
            #1;
            check("burst_req0_ready", 32'(req0_ready), 32'((i % 9) != 8));
            check("burst_req1_ready", 32'(req1_ready), 32'((i % 9) == 8));
            tick();
        end
        req1_valid = 1'b0;
`ifdef FB_ARB_STATS_EN
        #1;
        check("burst_starve_events", 32'(starve_events), 32'd2);
`endif

        // Clear sweep with req0 held throughout, plus an ignored second start.
        req0_addr = 12'h0AB; req0_data = 8'h5A;
        clear_start = 1'b1; clear_value = 8'h00;
        #1;
        check("clear_accept_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        clear_start = 1'b0;
        n_clear = 0; n_busy = 0; last_owner = 0;
        for (int i = 0; i < 20; i++) begin
            clear_start = 1'b0;
            #1;
            if (grant_owner == 2'd3 && ram_write_enable) begin
                check("clear_addr", 32'(ram_address),  32'(n_clear));
                check("clear_data", 32'(ram_data_out), 32'h00);
                n_clear++;
            end
            if (clear_busy) n_busy++;
            if (last_owner == 3 && grant_owner != 2'd3)
                check("post_clear_owner", 32'(grant_owner), 32'd1);
            last_owner = int'(grant_owner);
            if (grant_owner == 2'd3 && ram_address == 12'd5) begin
                clear_start = 1'b1;
                clear_value = 8'hEE;
            end
            tick();
        end
        clear_start = 1'b0;
        check("clear_write_count", 32'(n_clear), 32'd16);
        check("clear_busy_cycles", 32'(n_busy),  32'd16);
        req0_valid = 1'b0;

        // Reset in the middle of a sweep aborts it.
        tick();
        clear_start = 1'b1; clear_value = 8'h3C;
        tick();
        clear_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (grant_owner == 2'd3 && ram_address == 12'd7) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("abort_found_addr7", 32'(found), 32'd1);
        reset = 1'b0;
        tick();
        #1;
        check("abort_we",   32'(ram_write_enable), 32'd0);
        check("abort_busy", 32'(clear_busy),       32'd0);
        reset = 1'b1;
        n3 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant_owner == 2'd3) n3++;
        end
        check("abort_no_resume", 32'(n3), 32'd0);

        // Randomized traffic; a requester holds addr/data until accepted.
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!p0) begin
                req0_valid = ($urandom_range(3) != 0);
                req0_addr  = 12'($urandom);
                req0_data  = 8'($urandom);
            end
            if (!p1) begin
                req1_valid = ($urandom_range(2) == 0);
                req1_addr  = 12'($urandom);
                req1_data  = 8'($urandom);
            end
            clear_start = ($urandom_range(59) == 0);
            clear_value = 8'($urandom);
            reset       = ($urandom_range(299) != 0);
            #3;
            p0 = req0_valid && !req0_ready;
            p1 = req1_valid && !req1_ready;
            tick();
        end
        reset = 1'b1;
        clear_start = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
